// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end byte fetcher feeding the decode stage.
//
// Reads instruction memory one byte per cycle and decodes the instruction length
// from the opcode's upper nibble. On a two-word instruction it pulses ir_en while
// the immediate byte is on imm_byte. Each complete instruction is handed to decode
// over a valid/ready handshake.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   imem_addr / imem_data    instruction-memory address (from pc) / read byte
//   flush, flush_pc          redirect request and target
//   ir_en, imm_byte          immediate-capture enable and byte
//   out_valid / out_ready    decode handshake
//   out_opcode, out_imm,     issued instruction payload
//   out_two_word, out_pc
//
// Optional macro FETCH_STATS_EN adds stat_issued / stat_stall saturating counters.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [3:0]        MW_NIBBLE = 4'hC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              ir_en,
  output logic [7:0]        imm_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [7:0]        out_imm,
  output logic              out_two_word,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_stall
`endif
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    ISSUE     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        imm_q, imm_d;
  logic              two_word_q, two_word_d;
  logic [ADDR_W-1:0] opc_pc_q, opc_pc_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    imm_d      = imm_q;
    two_word_d = two_word_q;
    opc_pc_d   = opc_pc_q;
    ir_en      = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      FETCH_OP: begin
        opcode_d = imem_data;
        opc_pc_d = pc_q;
        pc_d     = pc_q + 1'b1;
        if (imem_data[7:4] == MW_NIBBLE) begin
          two_word_d = 1'b1;
          state_d    = FETCH_IMM;
        end else begin
          imm_d      = 8'h00;
          two_word_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      FETCH_IMM: begin
        ir_en   = 1'b1;
        imm_d   = imem_data;
        pc_d    = pc_q + 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = FETCH_OP;
      end
      default: state_d = FETCH_OP;
    endcase

    // Redirect overrides the normal step: the payload registers keep their old
    // contents (out_valid drops, so they are not observed) and only pc/state move.
    if (flush) begin
      state_d    = FETCH_OP;
      pc_d       = flush_pc;
      opcode_d   = opcode_q;
      imm_d      = imm_q;
      two_word_d = two_word_q;
      opc_pc_d   = opc_pc_q;
    end

    if (flush || rst) ir_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_OP;
      pc_q       <= RESET_PC;
      opcode_q   <= '0;
      imm_q      <= '0;
      two_word_q <= 1'b0;
      opc_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      imm_q      <= imm_d;
      two_word_q <= two_word_d;
      opc_pc_q   <= opc_pc_d;
    end
  end

  assign imem_addr    = pc_q;
  assign imm_byte     = imem_data;
  assign out_opcode   = opcode_q;
  assign out_imm      = imm_q;
  assign out_two_word = two_word_q;
  assign out_pc       = opc_pc_q;

`ifdef FETCH_STATS_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] stall_q, stall_d;

  // Counters survive flush; only rst clears them. Both stick at all-ones.
  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (out_valid && out_ready && !flush && (issued_q != '1))
      issued_d = issued_q + 16'd1;
    if (out_valid && !out_ready && (stall_q != '1))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end byte fetcher and the producer side of the immediate-capture interface.
- Reads the 8-bit instruction memory one byte per cycle.
- Decodes the instruction length from the opcode byte.
- On two-word instructions, asserts `ir_en` for exactly the cycle in which the immediate/address byte is presented on `imm_byte`.
- Presents each complete instruction (opcode, immediate, PC) to decode over a valid/ready handshake.
- Sits between instruction memory and the decode stage.

Parameters:
- ADDR_W, 8, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.
- MW_NIBBLE, 4'hC, opcode[7:4] value marking a two-word instruction (LDM/LDD/STD family).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  instruction-memory address; combinational from pc.
- imem_data  in  8  instruction-memory read data; valid in the same cycle as imem_addr.
- flush  in  1  redirect request (branch/jump).
- flush_pc  in  ADDR_W  redirect target.
- ir_en  out  1  immediate-capture enable to the immediate register.
- imm_byte  out  8  immediate/address byte to the immediate register.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_opcode  out  8  opcode byte.
- out_imm  out  8  immediate byte; 0x00 for single-word instructions.
- out_two_word  out  1  the issued instruction is two-word.
- out_pc  out  ADDR_W  address of the opcode byte.

Behaviour:
- All state changes on the rising edge of clk. Priority: rst > flush > normal operation.
- Reset values:
  - pc = RESET_PC; state = FETCH_OP.
  - out_valid = 0, out_opcode = 0x00, out_imm = 0x00, out_two_word = 0, out_pc = RESET_PC.
  - ir_en = 0.
- States:
  - FETCH_OP:
    - out_opcode <= imem_data; out_pc <= pc; pc <= pc+1.
    - If imem_data[7:4] == MW_NIBBLE: out_two_word <= 1, go to FETCH_IMM.
    - Otherwise: out_imm <= 0x00, out_two_word <= 0, go to ISSUE.
  - FETCH_IMM:
    - ir_en = 1 (combinational, this state only).
    - out_imm <= imem_data; pc <= pc+1; go to ISSUE.
  - ISSUE:
    - out_valid = 1; pc and all outputs held stable.
    - When out_ready = 1: go to FETCH_OP.
- ir_en is combinationally 0 in every state except FETCH_IMM, and 0 in any cycle where rst or flush is high.
- imm_byte = imem_data at all times; it is meaningful only while ir_en = 1.
- Latency:
  - Single-word: out_valid rises 1 cycle after the opcode fetch cycle.
  - Two-word: out_valid rises 2 cycles after the opcode fetch cycle.
  - Max throughput: 1 instruction per 2 cycles (single-word), 1 per 3 cycles (two-word), with out_ready tied high.
- Handshake:
  - out_valid is never dropped without acceptance, except on flush or rst.
  - Payload is stable while out_valid = 1 and out_ready = 0.
- PC arithmetic: ADDR_W-bit modulo; 0xFF+1 = 0x00. A two-word opcode at 0xFF takes its immediate from 0x00.
- flush, in any state:
  - pc <= flush_pc; state <= FETCH_OP; out_valid low from the next cycle.
  - Any in-flight or un-accepted instruction is discarded.
  - flush in FETCH_IMM suppresses ir_en in that cycle.
- flush and out_ready together in ISSUE: flush wins; the instruction counts as discarded, not accepted.
- rst mid-instruction: returns to the reset values on the next edge; no ir_en pulse.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Adds outputs stat_issued[15:0] and stat_stall[15:0]; both reset to 0, saturate at 0xFFFF, and are not cleared by flush.
  - stat_issued increments on each accepted handshake (out_valid & out_ready & !flush).
  - stat_stall increments each cycle with out_valid & !out_ready.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single-word: rst, memory {0x10, 0x20}, out_ready = 1 → issue opcode 0x10 (pc 0x00, imm 0x00, two_word 0), then opcode 0x20 (pc 0x01); ir_en never asserted.
- Two-word LDM: memory {0xC1, 0x42}, out_ready = 1 → ir_en = 1 for exactly one cycle with imm_byte = 0x42; issue opcode 0xC1, imm 0x42, two_word 1, pc 0x00; next fetch at 0x02.
- Backpressure: out_ready = 0 for 5 cycles while issuing 0xCA/0x90 → out_valid stays 1 with payload unchanged, imem_addr held at 0x02; accepted on the cycle out_ready = 1.
- Flush during FETCH_IMM: opcode 0xC5 at 0x10, flush = 1 with flush_pc = 0x40 in the immediate cycle → ir_en = 0, no issue of 0xC5; next opcode fetched from 0x40.
- Wrap: flush_pc = 0xFF, memory[0xFF] = 0xC5, memory[0x00] = 0x80 → issue pc 0xFF, imm 0x80; next fetch at 0x01.
- FETCH_STATS_EN: 3 accepted instructions plus 4 stalled cycles → stat_issued = 3, stat_stall = 4; rst returns both to 0.
